// File: rtl/lfsr_stream_gen.sv
// Galois LFSR pseudo-random stream generator with a valid/ready command port
// and a back-pressured output word stream.
module lfsr_stream_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int               OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             stop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int BCW = $clog2(OUT_W + 1);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_BURST = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        SHIFT   = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] lfsr_r;
    logic [WIDTH-1:0] remaining_r;
    logic [BCW-1:0]   bit_cnt_r;
    logic [OUT_W-1:0] out_data_r;
    logic             out_valid_r;
    logic             busy_r;

    logic [WIDTH-1:0] lfsr_next_s;
    logic             gen_bit_s;
    logic [OUT_W-1:0] bit_mask_s;
    logic             handshake_s;

    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
        galois_step = (s >> 1) ^ (s[0] ? TAPS : {WIDTH{1'b0}});
    endfunction

    // Next-state of the shift register and the bit slot being filled this cycle.
    always_comb begin
        lfsr_next_s = galois_step(lfsr_r);
        gen_bit_s   = lfsr_r[0];
        bit_mask_s  = OUT_W'(1'b1) << bit_cnt_r;
        handshake_s = out_valid_r & out_ready;
    end

    assign cmd_ready  = (state_r == IDLE);
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;
    assign lfsr_state = lfsr_r;

    // Command FSM, LFSR register, word packing and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            lfsr_r      <= SEED;
            remaining_r <= {WIDTH{1'b0}};
            bit_cnt_r   <= {BCW{1'b0}};
            out_data_r  <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                // A zero seed would lock the register, so fall back to SEED.
                                lfsr_r <= (cmd_arg == {WIDTH{1'b0}}) ? SEED : cmd_arg;
                            end
                            OP_BURST: begin
                                if (cmd_arg != {WIDTH{1'b0}}) begin
                                    remaining_r <= cmd_arg;
                                    bit_cnt_r   <= {BCW{1'b0}};
                                    state_r     <= SHIFT;
                                    busy_r      <= 1'b1;
                                end
                            end
                            OP_STEP: begin
                                state_r <= STEP;
                                busy_r  <= 1'b1;
                            end
                            default: begin
                                state_r <= IDLE;
                            end
                        endcase
                    end
                end
                STEP: begin
                    if (stop) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (en) begin
                        lfsr_r  <= lfsr_next_s;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (stop) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (en) begin
                        lfsr_r     <= lfsr_next_s;
                        out_data_r <= (out_data_r & ~bit_mask_s) | (gen_bit_s ? bit_mask_s : {OUT_W{1'b0}});
                        bit_cnt_r  <= bit_cnt_r + BCW'(1);
                        if (bit_cnt_r == BCW'(OUT_W - 1)) begin
                            out_valid_r <= 1'b1;
                            state_r     <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (handshake_s) begin
                        remaining_r <= remaining_r - WIDTH'(1);
                        out_valid_r <= 1'b0;
                        if (stop || (remaining_r == WIDTH'(1))) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            bit_cnt_r <= {BCW{1'b0}};
                            state_r   <= SHIFT;
                        end
                    end else if (stop) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
